// File: rtl/dac_sample_pacer.sv
// Sample FIFO that releases 10-bit codes to the DAC at a programmable, jitter-free rate.
// Includes priming, sticky underrun detection and a mid-scale hold after reset.
module dac_sample_pacer #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [DIV_W-1:0]          divisor,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      clr_underrun,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic [DATA_W-1:0]         dac_d,
  output logic                      dac_strobe,
  output logic                      underrun,
  output logic                      running
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic [DATA_W-1:0]  dac_q, dac_d_next;
  logic               strobe_q, strobe_d;
  logic               underrun_q, underrun_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               pop;
  logic               set_underrun;
  logic               wr_acc;

  // Next-state, pacing and FIFO bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    set_underrun = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!flush && (level_q >= LVL_W'(PRIME_LVL))) begin
          state_d = S_RUN;
          cnt_d   = divisor;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_PRIME;
        end else if (cnt_q == '0) begin
          cnt_d = divisor;
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            set_underrun = 1'b1;
            state_d      = S_PRIME;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides everything, including a tick in the same cycle
    if (!enable) begin
      state_d      = S_IDLE;
      cnt_d        = cnt_q;
      pop          = 1'b0;
      set_underrun = 1'b0;
    end

    wr_acc   = wr_en && !full_q && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_acc && !pop)      level_d = level_q + LVL_W'(1);
      else if (!wr_acc && pop) level_d = level_q - LVL_W'(1);
    end
    full_d = (level_d == LVL_W'(DEPTH));

    dac_d_next = pop ? mem_q[rd_ptr_q] : dac_q;
    strobe_d   = pop;
    underrun_d = set_underrun | (underrun_q & ~clr_underrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      dac_q      <= MID_SCALE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      dac_q      <= dac_d_next;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full       = full_q;
  assign level      = level_q;
  assign dac_d      = dac_q;
  assign dac_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign running    = (state_q == S_RUN);

endmodule
